// File: rtl/lpc_record_writer_if.sv
// Bundle of the decoded-LPC strobe input, the ring-buffer write port and the
// debug drop counter shared between the record writer and its neighbours.
interface lpc_record_writer_if #(
  parameter int DROP_W = 16
);
  logic              in_valid;
  logic              in_dir;
  logic [1:0]        in_cyctype;
  logic [31:0]       in_addr;
  logic [7:0]        in_data;
  logic              overflow;
  logic [47:0]       out_data;
  logic              out_clock_enable;
  logic [DROP_W-1:0] drop_count;

  // Writer side: consumes decoder strobes and ring-buffer status.
  modport slave (
    input  in_valid, in_dir, in_cyctype, in_addr, in_data, overflow,
    output out_data, out_clock_enable, drop_count
  );

  // Environment side: decoder plus ring buffer.
  modport master (
    output in_valid, in_dir, in_cyctype, in_addr, in_data, overflow,
    input  out_data, out_clock_enable, drop_count
  );
endinterface

// File: rtl/lpc_record_writer.sv
// Packs decoded LPC cycles into 48-bit records and writes them to the capture
// ring buffer. A 2-entry queue absorbs overflow back-pressure; records lost
// while the queue is full are counted and reported by an in-stream marker
// record placed where the first loss happened.
module lpc_record_writer #(
  parameter int DROP_W = 16
) (
  input logic                 clock,
  input logic                 reset,
  lpc_record_writer_if.slave  bus
);

  logic [47:0]       slot0_q, slot0_d;
  logic [47:0]       slot1_q, slot1_d;
  logic [1:0]        count_q, count_d;
  logic [1:0]        ahead_q, ahead_d;
  logic              pending_q, pending_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [47:0]       out_q, out_d;
  logic              ce_q, ce_d;

  logic [47:0] dataRec;
  logic [47:0] markerRec;
  logic        canEmit;
  logic        emitMarker;
  logic        pop;
  logic        bypass;
  logic        push;
  logic        drop;
  logic [1:0]  countAfterPop;

  // Decide this cycle's write (marker, queue head or direct bypass) and
  // whether the incoming strobe is queued, bypassed or dropped.
  always_comb begin
    dataRec       = {4'h1, bus.in_dir, bus.in_cyctype, 1'b0, bus.in_addr, bus.in_data};
    markerRec     = {8'hD0, {(40-DROP_W){1'b0}}, drop_q};
    canEmit       = !bus.overflow;
    emitMarker    = canEmit && pending_q && (ahead_q == 2'd0);
    pop           = canEmit && !emitMarker && (count_q != 2'd0);
    bypass        = canEmit && !emitMarker && (count_q == 2'd0) && bus.in_valid;
    countAfterPop = count_q - {1'b0, pop};
    push          = bus.in_valid && !bypass && (countAfterPop != 2'd2);
    drop          = bus.in_valid && !bypass && (countAfterPop == 2'd2);

    out_d     = out_q;
    ce_d      = 1'b0;
    slot0_d   = slot0_q;
    slot1_d   = slot1_q;
    count_d   = countAfterPop;
    ahead_d   = ahead_q;
    pending_d = pending_q;
    drop_d    = drop_q;

    if (emitMarker) begin
      out_d     = markerRec;
      ce_d      = 1'b1;
      pending_d = 1'b0;
      drop_d    = '0;
    end else if (pop) begin
      out_d   = slot0_q;
      ce_d    = 1'b1;
      slot0_d = slot1_q;
      if (ahead_q != 2'd0) begin
        ahead_d = ahead_q - 2'd1;
      end
    end else if (bypass) begin
      out_d = dataRec;
      ce_d  = 1'b1;
    end

    if (push) begin
      if (countAfterPop == 2'd0) begin
        slot0_d = dataRec;
      end else begin
        slot1_d = dataRec;
      end
      count_d = countAfterPop + 2'd1;
    end

    if (drop) begin
      if (emitMarker) begin
        drop_d = {{(DROP_W-1){1'b0}}, 1'b1};
      end else if (drop_q != {DROP_W{1'b1}}) begin
        drop_d = drop_q + 1'b1;
      end
      pending_d = 1'b1;
      if (!pending_q || emitMarker) begin
        ahead_d = countAfterPop;
      end
    end
  end

  // State and registered outputs; async active-low reset discards everything.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot0_q   <= '0;
      slot1_q   <= '0;
      count_q   <= '0;
      ahead_q   <= '0;
      pending_q <= 1'b0;
      drop_q    <= '0;
      out_q     <= '0;
      ce_q      <= 1'b0;
    end else begin
      slot0_q   <= slot0_d;
      slot1_q   <= slot1_d;
      count_q   <= count_d;
      ahead_q   <= ahead_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
      out_q     <= out_d;
      ce_q      <= ce_d;
    end
  end

  assign bus.out_data         = out_q;
  assign bus.out_clock_enable = ce_q;
  assign bus.drop_count       = drop_q;

endmodule

// File: tb/tb_lpc_record_writer.sv
// Directed bench for lpc_record_writer: latency, streaming, back-pressure,
// marker merge/saturation, async reset and push-during-pop on a full queue.
module tb_lpc_record_writer;

  logic clock;
  logic reset;
  int   checkCount;
  int   errorCount;

  lpc_record_writer_if #(.DROP_W(16)) bus ();

  lpc_record_writer #(.DROP_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10-unit clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hand-built vectors and their packed records.
  logic        vDir  [4];
  logic [1:0]  vType [4];
  logic [31:0] vAddr [4];
  logic [7:0]  vData [4];
  logic [47:0] vRec  [4];

  task automatic checkOutput(input string tag, input logic [47:0] observed,
                             input logic [47:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then return 1 unit after the rising edge.
  task automatic applyStimulus(input logic valid, input int idx, input logic ovf);
    bus.in_valid   = valid;
    bus.in_dir     = vDir[idx];
    bus.in_cyctype = vType[idx];
    bus.in_addr    = vAddr[idx];
    bus.in_data    = vData[idx];
    bus.overflow   = ovf;
    @(posedge clock);
    #1;
  endtask

  task automatic expectWrite(input string tag, input logic [47:0] rec);
    checkOutput({tag, "_ce"}, {47'd0, bus.out_clock_enable}, 48'd1);
    checkOutput({tag, "_data"}, bus.out_data, rec);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;

    vDir[0] = 1'b0; vType[0] = 2'd0; vAddr[0] = 32'h0000_03F8; vData[0] = 8'h11;
    vRec[0] = 48'h1_0_000003F8_11;
    vDir[1] = 1'b1; vType[1] = 2'd3; vAddr[1] = 32'h0000_0004; vData[1] = 8'hA5;
    vRec[1] = 48'h1_E_00000004_A5;
    vDir[2] = 1'b0; vType[2] = 2'd2; vAddr[2] = 32'hFFFF_FFF0; vData[2] = 8'h00;
    vRec[2] = 48'h1_4_FFFFFFF0_00;
    vDir[3] = 1'b1; vType[3] = 2'd0; vAddr[3] = 32'h1234_5678; vData[3] = 8'hFF;
    vRec[3] = 48'h1_8_12345678_FF;

    bus.in_valid = 1'b0; bus.in_dir = 1'b0; bus.in_cyctype = 2'd0;
    bus.in_addr = 32'd0; bus.in_data = 8'd0; bus.overflow = 1'b0;

    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_data", bus.out_data, 48'd0);
    checkOutput("rst_ce", {47'd0, bus.out_clock_enable}, 48'd0);
    checkOutput("rst_drop", {32'd0, bus.drop_count}, 48'd0);
    reset = 1'b1;
    applyStimulus(1'b0, 0, 1'b0);

    // Single strobe: write visible one cycle later
    bus.in_valid = 1'b1; bus.in_dir = 1'b1; bus.in_cyctype = 2'd1;
    bus.in_addr = 32'h0000_0080; bus.in_data = 8'h55; bus.overflow = 1'b0;
    @(posedge clock);
    #1;
    expectWrite("single", 48'h1_A_00000080_55);
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("single_idle_ce", {47'd0, bus.out_clock_enable}, 48'd0);
    checkOutput("single_hold", bus.out_data, 48'h1_A_00000080_55);

    // Back-to-back: four strobes stream straight through
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, i, 1'b0);
      expectWrite($sformatf("b2b%0d", i), vRec[i]);
    end
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("b2b_idle_ce", {47'd0, bus.out_clock_enable}, 48'd0);
    checkOutput("b2b_drop", {32'd0, bus.drop_count}, 48'd0);

    // Back-pressure: A,B queued, C,D dropped into one marker
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, i, 1'b1);
      checkOutput($sformatf("bp_hold_ce%0d", i), {47'd0, bus.out_clock_enable}, 48'd0);
    end
    checkOutput("bp_drop2", {32'd0, bus.drop_count}, 48'd2);
    applyStimulus(1'b0, 0, 1'b0);
    expectWrite("bp_A", vRec[0]);
    applyStimulus(1'b0, 0, 1'b0);
    expectWrite("bp_B", vRec[1]);
    applyStimulus(1'b0, 0, 1'b0);
    expectWrite("bp_marker", 48'hD000_0000_0002);
    checkOutput("bp_drop_clr", {32'd0, bus.drop_count}, 48'd0);
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("bp_idle_ce", {47'd0, bus.out_clock_enable}, 48'd0);

    // Merge and saturation, then a drop in the marker cycle re-arms
    applyStimulus(1'b1, 0, 1'b1);
    applyStimulus(1'b1, 1, 1'b1);
    for (int i = 0; i < 70000; i++) begin
      applyStimulus(1'b1, 2, 1'b1);
    end
    checkOutput("sat_drop", {32'd0, bus.drop_count}, 48'h0000_0000_FFFF);
    checkOutput("sat_ce", {47'd0, bus.out_clock_enable}, 48'd0);
    applyStimulus(1'b1, 3, 1'b0);
    expectWrite("sat_P", vRec[0]);
    applyStimulus(1'b1, 0, 1'b0);
    expectWrite("sat_Q", vRec[1]);
    applyStimulus(1'b1, 1, 1'b0);
    expectWrite("sat_marker", 48'hD000_0000_FFFF);
    checkOutput("sat_rearm_drop", {32'd0, bus.drop_count}, 48'd1);
    applyStimulus(1'b0, 0, 1'b0);
    expectWrite("sat_E", vRec[3]);
    applyStimulus(1'b0, 0, 1'b0);
    expectWrite("sat_F", vRec[0]);
    applyStimulus(1'b0, 0, 1'b0);
    expectWrite("sat_marker2", 48'hD000_0000_0001);
    checkOutput("sat_drop_clr", {32'd0, bus.drop_count}, 48'd0);
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("sat_idle_ce", {47'd0, bus.out_clock_enable}, 48'd0);

    // Async reset with two queued records and a pending marker
    applyStimulus(1'b1, 0, 1'b1);
    applyStimulus(1'b1, 1, 1'b1);
    applyStimulus(1'b1, 2, 1'b1);
    checkOutput("ar_pre_drop", {32'd0, bus.drop_count}, 48'd1);
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("ar_data", bus.out_data, 48'd0);
    checkOutput("ar_ce", {47'd0, bus.out_clock_enable}, 48'd0);
    checkOutput("ar_drop", {32'd0, bus.drop_count}, 48'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 0, 1'b0);
      checkOutput($sformatf("ar_nowrite%0d", i), {47'd0, bus.out_clock_enable}, 48'd0);
    end
    checkOutput("ar_data_after", bus.out_data, 48'd0);

    // Push during pop on a full queue as overflow falls
    applyStimulus(1'b1, 2, 1'b1);
    applyStimulus(1'b1, 3, 1'b1);
    applyStimulus(1'b1, 0, 1'b0);
    expectWrite("pp_head", vRec[2]);
    checkOutput("pp_drop", {32'd0, bus.drop_count}, 48'd0);
    applyStimulus(1'b0, 0, 1'b0);
    expectWrite("pp_second", vRec[3]);
    applyStimulus(1'b0, 0, 1'b0);
    expectWrite("pp_pushed", vRec[0]);
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("pp_idle_ce", {47'd0, bus.out_clock_enable}, 48'd0);
    checkOutput("pp_drop_end", {32'd0, bus.drop_count}, 48'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
